blend_factor_stage: RTL and testbench

- Upstream feeder and flow controller for the colour mixer: takes source fragment colour and destination framebuffer colour with a valid/ready handshake.
- Decodes the configured source and destination blend functions into per-channel factors and registers the four mixer operands: colorA = src, colorB = srcFactor, colorC = dst, colorD = dstFactor.
- Drives the mixer's `ce` and tracks validity and sideband index through the 2-cycle mixer.
- Re-emits the mixed result on a valid/ready output, so the blend path looks like one stallable pipeline.

---
 rtl/blend_pkg.sv | 31 +++
 rtl/blend_factor_decode.sv | 43 ++++
 rtl/blend_factor_stage.sv | 109 ++++++++++
 tb/tb_blend_factor_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blend_pkg.sv
// Shared definitions for the blend factor stage: function codes, channel map, width helper.
package blend_pkg;

  // Blend function codes as held in the configuration registers
  typedef enum logic [3:0] {
    BLEND_ZERO                = 4'd0,
    BLEND_ONE                 = 4'd1,
    BLEND_DST_COLOR           = 4'd2,
    BLEND_SRC_COLOR           = 4'd3,
    BLEND_ONE_MINUS_DST_COLOR = 4'd4,
    BLEND_ONE_MINUS_SRC_COLOR = 4'd5,
    BLEND_SRC_ALPHA           = 4'd6,
    BLEND_ONE_MINUS_SRC_ALPHA = 4'd7,
    BLEND_DST_ALPHA           = 4'd8,
    BLEND_ONE_MINUS_DST_ALPHA = 4'd9,
    BLEND_SRC_ALPHA_SATURATE  = 4'd10
  } blend_func_e;

  // Channel positions within a pixel (R in the MSBs, A in the LSBs)
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_R   = 3;
  localparam int unsigned CH_G   = 2;
  localparam int unsigned CH_B   = 1;
  localparam int unsigned CH_A   = 0;

  // Total pixel width for a given channel width
  function automatic int unsigned pixel_width(input int unsigned sub_w);
    return NUM_CH * sub_w;
  endfunction

endpackage

// File: rtl/blend_factor_decode.sv
// Combinational decode of one blend function code into a per-channel factor.
module blend_factor_decode
  import blend_pkg::*;
#(
  parameter int unsigned SUB_PIXEL_WIDTH = 8
) (
  input  logic [3:0]                                i_func,
  input  logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   i_src,
  input  logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   i_dst,
  output logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   o_factor
);

  localparam int unsigned W = SUB_PIXEL_WIDTH;

  logic [W-1:0] w_as;
  logic [W-1:0] w_ad;
  logic [W-1:0] w_inv_ad;
  logic [W-1:0] w_sat;

  // Select the factor; unknown codes (11-15) fall through to ZERO
  always_comb begin
    w_as     = i_src[CH_A*W +: W];
    w_ad     = i_dst[CH_A*W +: W];
    w_inv_ad = ~w_ad;
    w_sat    = (w_as < w_inv_ad) ? w_as : w_inv_ad;
    o_factor = '0;
    case (i_func)
      BLEND_ZERO:                o_factor = '0;
      BLEND_ONE:                 o_factor = '1;
      BLEND_DST_COLOR:           o_factor = i_dst;
      BLEND_SRC_COLOR:           o_factor = i_src;
      BLEND_ONE_MINUS_DST_COLOR: o_factor = ~i_dst;
      BLEND_ONE_MINUS_SRC_COLOR: o_factor = ~i_src;
      BLEND_SRC_ALPHA:           o_factor = {NUM_CH{w_as}};
      BLEND_ONE_MINUS_SRC_ALPHA: o_factor = {NUM_CH{~w_as}};
      BLEND_DST_ALPHA:           o_factor = {NUM_CH{w_ad}};
      BLEND_ONE_MINUS_DST_ALPHA: o_factor = {NUM_CH{w_inv_ad}};
      BLEND_SRC_ALPHA_SATURATE:  o_factor = {{(NUM_CH-1){w_sat}}, {W{1'b1}}};
      default:                   o_factor = '0;
    endcase
  end

endmodule

// File: rtl/blend_factor_stage.sv
// Blend front end: decodes factors, registers mixer operands and tracks
// valid/index through the mixer so the whole path stalls as one pipeline.
module blend_factor_stage
  import blend_pkg::*;
#(
  parameter int unsigned SUB_PIXEL_WIDTH = 8,
  parameter int unsigned INDEX_WIDTH     = 16,
  parameter int unsigned MIXER_LATENCY   = 2
) (
  input  logic                                      aclk,
  input  logic                                      resetn,
  input  logic                                      conf_valid,
  input  logic [3:0]                                conf_src_func,
  input  logic [3:0]                                conf_dst_func,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  input  logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   s_src_color,
  input  logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   s_dst_color,
  input  logic [INDEX_WIDTH-1:0]                    s_index,
  output logic                                      mixer_ce,
  output logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   colorA,
  output logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   colorB,
  output logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   colorC,
  output logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   colorD,
  input  logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   mixer_color,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic [pixel_width(SUB_PIXEL_WIDTH)-1:0]   m_color,
  output logic [INDEX_WIDTH-1:0]                    m_index
);

  localparam int unsigned PW = pixel_width(SUB_PIXEL_WIDTH);

  logic [3:0]             r_src_func;
  logic [3:0]             r_dst_func;
  logic [PW-1:0]          w_src_factor;
  logic [PW-1:0]          w_dst_factor;
  logic                   w_advance;
  logic                   r_vld [0:MIXER_LATENCY];
  logic [INDEX_WIDTH-1:0] r_idx [0:MIXER_LATENCY];

  blend_factor_decode #(.SUB_PIXEL_WIDTH(SUB_PIXEL_WIDTH)) u_src_decode (
    .i_func   (r_src_func),
    .i_src    (s_src_color),
    .i_dst    (s_dst_color),
    .o_factor (w_src_factor)
  );

  blend_factor_decode #(.SUB_PIXEL_WIDTH(SUB_PIXEL_WIDTH)) u_dst_decode (
    .i_func   (r_dst_func),
    .i_src    (s_src_color),
    .i_dst    (s_dst_color),
    .o_factor (w_dst_factor)
  );

  // A held output freezes every stage, bubbles included
  always_comb begin
    w_advance = !m_valid || m_ready;
    s_ready   = w_advance;
    mixer_ce  = w_advance;
    m_valid   = r_vld[MIXER_LATENCY];
    m_index   = r_idx[MIXER_LATENCY];
    m_color   = mixer_color;
  end

  // Function registers; a fragment accepted alongside conf_valid sees the old codes
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_src_func <= BLEND_ONE;
      r_dst_func <= BLEND_ZERO;
    end else if (conf_valid) begin
      r_src_func <= conf_src_func;
      r_dst_func <= conf_dst_func;
    end
  end

  // Mixer operand registers
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      colorA <= '0;
      colorB <= '0;
      colorC <= '0;
      colorD <= '0;
    end else if (w_advance) begin
      colorA <= s_src_color;
      colorB <= w_src_factor;
      colorC <= s_dst_color;
      colorD <= w_dst_factor;
    end
  end

  // Valid/index tracking: stage 0 aligns with the operands, last stage with mixer output
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i <= MIXER_LATENCY; i++) begin
        r_vld[i] <= 1'b0;
        r_idx[i] <= '0;
      end
    end else if (w_advance) begin
      r_vld[0] <= s_valid && s_ready;
      r_idx[0] <= s_index;
      for (int unsigned i = 1; i <= MIXER_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

endmodule

// File: tb/tb_blend_factor_stage.sv
// Directed bench for blend_factor_stage with a 2-cycle ce-enabled mixer stub.
module tb_blend_factor_stage;

  logic        aclk = 1'b0;
  logic        resetn;
  logic        conf_valid;
  logic [3:0]  conf_src_func;
  logic [3:0]  conf_dst_func;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_src_color;
  logic [31:0] s_dst_color;
  logic [15:0] s_index;
  logic        mixer_ce;
  logic [31:0] colorA, colorB, colorC, colorD;
  logic [31:0] mixer_color;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_color;
  logic [15:0] m_index;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mix_st1 = '0;
  logic [31:0] mix_st2 = '0;

  always #5 aclk = ~aclk;

  blend_factor_stage #(
    .SUB_PIXEL_WIDTH(8),
    .INDEX_WIDTH(16),
    .MIXER_LATENCY(2)
  ) dut (
    .aclk          (aclk),
    .resetn        (resetn),
    .conf_valid    (conf_valid),
    .conf_src_func (conf_src_func),
    .conf_dst_func (conf_dst_func),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_src_color   (s_src_color),
    .s_dst_color   (s_dst_color),
    .s_index       (s_index),
    .mixer_ce      (mixer_ce),
    .colorA        (colorA),
    .colorB        (colorB),
    .colorC        (colorC),
    .colorD        (colorD),
    .mixer_color   (mixer_color),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_color       (m_color),
    .m_index       (m_index)
  );

  // Mixer stub: (A&B)|(C&D), two ce-enabled stages
  always @(posedge aclk) begin
    if (mixer_ce) begin
      mix_st1 <= (colorA & colorB) | (colorC & colorD);
      mix_st2 <= mix_st1;
    end
  end
  assign mixer_color = mix_st2;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic configure(input logic [3:0] sf, input logic [3:0] df);
    conf_valid = 1'b1; conf_src_func = sf; conf_dst_func = df;
    tick();
    conf_valid = 1'b0;
  endtask

  task automatic drain;
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset;
    resetn = 1'b0; conf_valid = 1'b0; conf_src_func = '0; conf_dst_func = '0;
    s_valid = 1'b0; s_src_color = '0; s_dst_color = '0; s_index = '0; m_ready = 1'b0;
    repeat (3) tick();
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
    n_vec++; if ({colorA, colorB, colorC, colorD} !== 128'h0) begin n_err++;
      $display("FAIL reset_colors: got %h expected 0", {colorA, colorB, colorC, colorD}); end
    n_vec++; if (m_index !== 16'h0) begin n_err++; $display("FAIL reset_m_index: got %h expected 0000", m_index); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_defaults;
    m_ready = 1'b1; s_valid = 1'b1;
    s_src_color = 32'h80402010; s_dst_color = 32'hFFFFFFFF; s_index = 16'h1234;
    tick();
    s_valid = 1'b0;
    n_vec++; if (colorA !== 32'h80402010) begin n_err++; $display("FAIL def_colorA: got %h expected 80402010", colorA); end
    n_vec++; if (colorB !== 32'hFFFFFFFF) begin n_err++; $display("FAIL def_colorB: got %h expected FFFFFFFF", colorB); end
    n_vec++; if (colorC !== 32'hFFFFFFFF) begin n_err++; $display("FAIL def_colorC: got %h expected FFFFFFFF", colorC); end
    n_vec++; if (colorD !== 32'h00000000) begin n_err++; $display("FAIL def_colorD: got %h expected 00000000", colorD); end
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL def_lat1: got %b expected 0", m_valid); end
    tick();
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL def_lat2: got %b expected 0", m_valid); end
    tick();
    n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL def_lat3: got %b expected 1", m_valid); end
    n_vec++; if (m_index !== 16'h1234) begin n_err++; $display("FAIL def_index: got %h expected 1234", m_index); end
    n_vec++; if (m_color !== 32'h80402010) begin n_err++; $display("FAIL def_m_color: got %h expected 80402010", m_color); end
    tick();
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL def_consumed: got %b expected 0", m_valid); end
  endtask

  task automatic test_decode_table;
    logic [3:0]  codes [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12};
    logic [31:0] exps  [12] = '{32'h00000000, 32'hFFFFFFFF, 32'h55667788, 32'h11223344,
                                32'hAA998877, 32'hEEDDCCBB, 32'h44444444, 32'hBBBBBBBB,
                                32'h88888888, 32'h77777777, 32'h444444FF, 32'h00000000};
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      configure(codes[i], codes[i]);
      s_valid = 1'b1; s_src_color = 32'h11223344; s_dst_color = 32'h55667788; s_index = 16'(i);
      tick();
      s_valid = 1'b0;
      n_vec++; if (colorB !== exps[i]) begin n_err++;
        $display("FAIL decode_src code %0d: got %h expected %h", codes[i], colorB, exps[i]); end
      n_vec++; if (colorD !== exps[i]) begin n_err++;
        $display("FAIL decode_dst code %0d: got %h expected %h", codes[i], colorD, exps[i]); end
    end
    drain();
  endtask

  task automatic test_src_alpha;
    configure(4'd6, 4'd7);
    s_valid = 1'b1; s_src_color = 32'hFF000040; s_dst_color = 32'h12345678; s_index = 16'h0042;
    tick();
    s_valid = 1'b0;
    n_vec++; if (colorB !== 32'h40404040) begin n_err++; $display("FAIL src_alpha_B: got %h expected 40404040", colorB); end
    n_vec++; if (colorD !== 32'hBFBFBFBF) begin n_err++; $display("FAIL src_alpha_D: got %h expected BFBFBFBF", colorD); end
    drain();
  endtask

  task automatic test_saturate;
    configure(4'd10, 4'd0);
    s_valid = 1'b1; s_src_color = 32'h000000C0; s_dst_color = 32'h00000080; s_index = 16'h0043;
    tick();
    s_valid = 1'b0;
    n_vec++; if (colorB !== 32'h7F7F7FFF) begin n_err++; $display("FAIL saturate_B: got %h expected 7F7F7FFF", colorB); end
    n_vec++; if (colorD !== 32'h00000000) begin n_err++; $display("FAIL saturate_D: got %h expected 00000000", colorD); end
    drain();
  endtask

  task automatic test_back_to_back;
    logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          nxt = 1;
    int          expi = 1;
    int          cyc = 0;
    logic        held = 1'b0;
    logic        acc;
    logic        fire;
    logic [31:0] h_color = '0;
    logic [15:0] h_index = '0;
    configure(4'd1, 4'd0);
    drain();
    while (expi <= 8 && cyc < 100) begin
      m_ready = pat[cyc % 4];
      s_valid = (nxt <= 8);
      s_src_color = 32'hA5000000 | 32'(nxt);
      s_dst_color = 32'h0;
      s_index = 16'(nxt);
      #1;
      if (held) begin
        n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b expected 1", m_valid); end
        n_vec++; if (m_color !== h_color) begin n_err++; $display("FAIL stall_color: got %h expected %h", m_color, h_color); end
        n_vec++; if (m_index !== h_index) begin n_err++; $display("FAIL stall_index: got %h expected %h", m_index, h_index); end
      end
      n_vec++; if (s_ready !== (!m_valid || m_ready)) begin n_err++;
        $display("FAIL s_ready: got %b expected %b", s_ready, !m_valid || m_ready); end
      acc  = s_valid && s_ready;
      fire = m_valid && m_ready;
      if (fire) begin
        n_vec++; if (m_index !== 16'(expi)) begin n_err++; $display("FAIL order_index: got %h expected %h", m_index, 16'(expi)); end
        n_vec++; if (m_color !== (32'hA5000000 | 32'(expi))) begin n_err++;
          $display("FAIL order_color: got %h expected %h", m_color, 32'hA5000000 | 32'(expi)); end
        expi++;
      end
      held = m_valid && !m_ready;
      h_color = m_color;
      h_index = m_index;
      tick();
      if (acc) nxt++;
      cyc++;
    end
    n_vec++; if (expi != 9) begin n_err++; $display("FAIL stream_complete: got %0d outputs expected 8", expi - 1); end
    drain();
  endtask

  task automatic test_config_race;
    m_ready = 1'b1;
    s_valid = 1'b1; s_src_color = 32'h01020304; s_dst_color = 32'hFFFFFFFF; s_index = 16'd5;
    conf_valid = 1'b1; conf_src_func = 4'd1; conf_dst_func = 4'd1;
    tick();
    conf_valid = 1'b0;
    n_vec++; if (colorD !== 32'h00000000) begin n_err++; $display("FAIL race_idx5_D: got %h expected 00000000", colorD); end
    s_index = 16'd6;
    tick();
    s_valid = 1'b0;
    n_vec++; if (colorD !== 32'hFFFFFFFF) begin n_err++; $display("FAIL race_idx6_D: got %h expected FFFFFFFF", colorD); end
    tick();
    n_vec++; if (m_index !== 16'd5 || m_valid !== 1'b1) begin n_err++;
      $display("FAIL race_out5: got %b/%h expected 1/0005", m_valid, m_index); end
    tick();
    n_vec++; if (m_index !== 16'd6 || m_valid !== 1'b1) begin n_err++;
      $display("FAIL race_out6: got %b/%h expected 1/0006", m_valid, m_index); end
    drain();
  endtask

  task automatic test_reset_midstream;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_src_color = 32'h10203040; s_dst_color = 32'hFFFFFFFF; s_index = 16'(20 + i);
      tick();
    end
    s_valid = 1'b0;
    n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL mid_before: got %b expected 1", m_valid); end
    resetn = 1'b0;
    #1;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_async: got %b expected 0", m_valid); end
    n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL mid_s_ready: got %b expected 1", s_ready); end
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_quiet cycle %0d: got %b expected 0", i, m_valid); end
    end
    s_valid = 1'b1; s_src_color = 32'h10203040; s_dst_color = 32'hFFFFFFFF; s_index = 16'd30;
    tick();
    s_valid = 1'b0;
    n_vec++; if (colorD !== 32'h00000000) begin n_err++; $display("FAIL mid_func_reset_D: got %h expected 00000000", colorD); end
    n_vec++; if (colorB !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mid_func_reset_B: got %h expected FFFFFFFF", colorB); end
    drain();
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_decode_table();
    test_src_alpha();
    test_saturate();
    test_back_to_back();
    test_config_race();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
